// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending machine: coin encoding,
// FSM state encoding and the coin helper functions.
package vending_pkg;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_COLLECT,
        S_VEND,
        S_CHANGE,
        S_DONE
    } state_t;

    // Face value of a coin code.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 4'd1;
            COIN_2:  return 4'd2;
            COIN_5:  return 4'd5;
            default: return 4'd10;
        endcase
    endfunction

    // Largest coin not exceeding the amount still owed.
    function automatic logic [1:0] greedy_coin(input int unsigned remaining);
        if (remaining >= 10)
            return COIN_10;
        else if (remaining >= 5)
            return COIN_5;
        else if (remaining >= 2)
            return COIN_2;
        else
            return COIN_1;
    endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Serial change dispenser: loaded with an amount, it emits one greedy coin
// per cycle (first coin in the cycle after the load) until nothing is owed.
module vm_change_dispenser
    import vending_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         change_valid,
    output logic [1:0]   change_coin,
    output logic [W-1:0] remaining,
    output logic         empty
);

    logic [W-1:0] remaining_reg;
    logic         change_valid_reg;
    logic [1:0]   change_coin_reg;

    logic [W-1:0] src_amount;
    logic [1:0]   next_coin;
    logic [W-1:0] next_value;

    // Pick the next coin from either the freshly loaded amount or what is still owed.
    always_comb begin
        src_amount = load ? load_value : remaining_reg;
        next_coin  = greedy_coin(32'(src_amount));
        next_value = W'(coin_value(next_coin));
    end

    // Emit one coin per cycle while an amount is owed; idle outputs are zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining_reg    <= '0;
            change_valid_reg <= 1'b0;
            change_coin_reg  <= 2'b00;
        end else if (load || remaining_reg != '0) begin
            change_valid_reg <= 1'b1;
            change_coin_reg  <= next_coin;
            remaining_reg    <= src_amount - next_value;
        end else begin
            change_valid_reg <= 1'b0;
            change_coin_reg  <= 2'b00;
        end
    end

    assign change_valid = change_valid_reg;
    assign change_coin  = change_coin_reg;
    assign remaining    = remaining_reg;
    assign empty        = (remaining_reg == '0);

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: selection with stock check, coin
// collection, one-cycle vend, serial greedy change, cancel/refund, restock.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int PRICE_W      = 5,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = {5'd7, 5'd5, 5'd3, 5'd2},
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 3,
    localparam int SEL_W       = $clog2(NUM_PRODUCTS),
    localparam int CREDIT_W    = PRICE_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    coin_valid,
    input  logic [1:0]              coin,
    input  logic                    cancel,
    input  logic                    restock,
    output logic                    busy,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    product_valid,
    output logic [SEL_W-1:0]        product_id,
    output logic                    change_valid,
    output logic [1:0]              change_coin,
    output logic                    done,
    output logic                    err,
    output logic [NUM_PRODUCTS-1:0] sold_out
);

    state_t              state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [PRICE_W-1:0]  price_reg;
    logic                product_valid_reg;
    logic [SEL_W-1:0]    product_id_reg;
    logic                done_reg;
    logic                err_reg;

    logic [CREDIT_W-1:0] coin_credit;
    logic [CREDIT_W-1:0] collect_total;
    logic [CREDIT_W-1:0] vend_change;
    logic [PRICE_W-1:0]  sel_price;
    logic                sel_ok;
    logic                disp_load;
    logic [CREDIT_W-1:0] disp_value;
    logic [CREDIT_W-1:0] disp_remaining;
    logic                disp_empty;

    // Per-product stock counters; selection guarantees a counter is nonzero before it decrements.
    for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
        logic [STOCK_W-1:0] stock_reg;

        always_ff @(posedge clk) begin
            if (!rst)
                stock_reg <= STOCK_W'(INIT_STOCK);
            else if (state_reg == S_IDLE && restock && !start)
                stock_reg <= STOCK_W'(INIT_STOCK);
            else if (state_reg == S_VEND && sel_reg == SEL_W'(gi))
                stock_reg <= stock_reg - 1'b1;
        end

        assign sold_out[gi] = (stock_reg == '0);
    end

    // Credit arithmetic, selection validity and change-dispenser load requests.
    always_comb begin
        coin_credit   = credit_reg + CREDIT_W'(coin_value(coin));
        collect_total = coin_valid ? coin_credit : credit_reg;
        vend_change   = credit_reg - CREDIT_W'(price_reg);
        sel_price     = PRICES[int'(sel)*PRICE_W +: PRICE_W];
        sel_ok        = (int'(sel) < NUM_PRODUCTS) && !sold_out[sel];
        disp_load     = 1'b0;
        disp_value    = '0;
        if (state_reg == S_COLLECT && cancel && collect_total != '0) begin
            disp_load  = 1'b1;
            disp_value = collect_total;
        end else if (state_reg == S_VEND && vend_change != '0) begin
            disp_load  = 1'b1;
            disp_value = vend_change;
        end
    end

    // Transaction FSM with registered strobes (all strobes default low each cycle).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg         <= S_IDLE;
            credit_reg        <= '0;
            sel_reg           <= '0;
            price_reg         <= '0;
            product_valid_reg <= 1'b0;
            product_id_reg    <= '0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            product_valid_reg <= 1'b0;
            product_id_reg    <= '0;
            done_reg          <= 1'b0;
            err_reg           <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start)
                        state_reg <= S_SELECT;
                end
                S_SELECT: begin
                    if (cancel) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else if (sel_valid) begin
                        if (sel_ok) begin
                            sel_reg   <= sel;
                            price_reg <= sel_price;
                            state_reg <= S_COLLECT;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        // Refund goes through the dispenser; nothing to refund goes straight to DONE.
                        credit_reg <= '0;
                        if (collect_total != '0) begin
                            state_reg <= S_CHANGE;
                        end else begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        credit_reg <= coin_credit;
                        if (coin_credit >= CREDIT_W'(price_reg)) begin
                            state_reg         <= S_VEND;
                            product_valid_reg <= 1'b1;
                            product_id_reg    <= sel_reg;
                        end
                    end
                end
                S_VEND: begin
                    credit_reg <= '0;
                    if (vend_change != '0) begin
                        state_reg <= S_CHANGE;
                    end else begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_CHANGE: begin
                    if (disp_empty) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    credit_reg <= '0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    vm_change_dispenser #(
        .W (CREDIT_W)
    ) u_change (
        .clk          (clk),
        .rst          (rst),
        .load         (disp_load),
        .load_value   (disp_value),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .remaining    (disp_remaining),
        .empty        (disp_empty)
    );

    assign busy          = (state_reg != S_IDLE);
    assign credit        = (state_reg == S_CHANGE) ? disp_remaining : credit_reg;
    assign product_valid = product_valid_reg;
    assign product_id    = product_id_reg;
    assign done          = done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: tests push timed expected
// strobe events, a negedge monitor pops and compares them.
module tb_vending_machine_multi;
    import vending_pkg::*;

    localparam int NP       = 4;
    localparam int SEL_W    = 2;
    localparam int CREDIT_W = 6;

    localparam int EV_PROD   = 0;
    localparam int EV_CHANGE = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ERR    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              sel_valid = 1'b0;
    logic [SEL_W-1:0]  sel = '0;
    logic              coin_valid = 1'b0;
    logic [1:0]        coin = 2'b00;
    logic              cancel = 1'b0;
    logic              restock = 1'b0;
    logic              busy;
    logic [CREDIT_W-1:0] credit;
    logic              product_valid;
    logic [SEL_W-1:0]  product_id;
    logic              change_valid;
    logic [1:0]        change_coin;
    logic              done;
    logic              err;
    logic [NP-1:0]     sold_out;

    always #5 clk = ~clk;

    vending_machine_multi #(
        .NUM_PRODUCTS (4),
        .PRICE_W      (5),
        .PRICES       ({5'd7, 5'd5, 5'd3, 5'd2}),
        .STOCK_W      (4),
        .INIT_STOCK   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sel_valid     (sel_valid),
        .sel           (sel),
        .coin_valid    (coin_valid),
        .coin          (coin),
        .cancel        (cancel),
        .restock       (restock),
        .busy          (busy),
        .credit        (credit),
        .product_valid (product_valid),
        .product_id    (product_id),
        .change_valid  (change_valid),
        .change_coin   (change_coin),
        .done          (done),
        .err           (err),
        .sold_out      (sold_out)
    );

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  stock_m[NP];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NP-1:0] sold_model();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = (stock_m[i] == 0);
        return r;
    endfunction

    // Monitor: every observed strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            ev_t obs[$];
            ev_t e;
            obs = {};
            if (product_valid) obs.push_back('{EV_PROD, int'(product_id), cyc});
            if (change_valid)  obs.push_back('{EV_CHANGE, int'(change_coin), cyc});
            if (done)          obs.push_back('{EV_DONE, 0, cyc});
            if (err)           obs.push_back('{EV_ERR, 0, cyc});
            foreach (obs[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event kind=%0d val=%0d cyc=%0d, required no event",
                             obs[i].kind, obs[i].val, obs[i].at);
                end else begin
                    e = exp_q.pop_front();
                    if (obs[i].kind !== e.kind || obs[i].val !== e.val || obs[i].at !== e.at) begin
                        failures++;
                        $display("FAIL event got kind=%0d val=%0d cyc=%0d required kind=%0d val=%0d cyc=%0d",
                                 obs[i].kind, obs[i].val, obs[i].at, e.kind, e.val, e.at);
                    end
                end
            end
            if (!product_valid) begin
                checks++;
                if (product_id !== '0) begin
                    failures++;
                    $display("FAIL idle_product_id got=%0d required=0", product_id);
                end
            end
            if (!change_valid) begin
                checks++;
                if (change_coin !== 2'b00) begin
                    failures++;
                    $display("FAIL idle_change_coin got=%0d required=0", change_coin);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_sel(input logic [SEL_W-1:0] s);
        sel_valid = 1'b1; sel = s; tick(); sel_valid = 1'b0; sel = '0;
    endtask

    task automatic pulse_coin(input logic [1:0] c);
        coin_valid = 1'b1; coin = c; tick(); coin_valid = 1'b0; coin = 2'b00;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    task automatic pulse_restock();
        restock = 1'b1; tick(); restock = 1'b0;
    endtask

    task automatic push(input int kind, input int val, input int at);
        exp_q.push_back('{kind, val, at});
    endtask

    // Wait (bounded) until every expected event has been seen.
    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q = {};
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < NP; i++) stock_m[i] = 3;
        checks++;
        if (busy !== 1'b0 || credit !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%0b credit=%0d required busy=0 credit=0", busy, credit);
        end
        checks++;
        if (sold_out !== 4'b0000) begin
            failures++;
            $display("FAIL reset_sold_out got=%b required=0000", sold_out);
        end
        checks++;
        if ({product_valid, change_valid, done, err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b required=0000", {product_valid, change_valid, done, err});
        end
    endtask

    task automatic test_exact_pay();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL exact_busy got=%0b required=1", busy);
        end
        pulse_sel(2'd1);
        pulse_coin(COIN_1);
        push(EV_PROD, 1, cyc + 1);
        push(EV_DONE, 0, cyc + 2);
        pulse_coin(COIN_2);
        checks++;
        if (credit !== 6'd3) begin
            failures++;
            $display("FAIL exact_vend_credit got=%0d required=3", credit);
        end
        drain();
        stock_m[1]--;
        checks++;
        if (busy !== 1'b0 || credit !== '0) begin
            failures++;
            $display("FAIL exact_end busy=%0b credit=%0d required busy=0 credit=0", busy, credit);
        end
    endtask

    task automatic test_overpay();
        pulse_start();
        pulse_sel(2'd3);
        pulse_coin(COIN_5);
        push(EV_PROD, 3, cyc + 1);
        push(EV_CHANGE, int'(COIN_5), cyc + 2);
        push(EV_CHANGE, int'(COIN_2), cyc + 3);
        push(EV_CHANGE, int'(COIN_1), cyc + 4);
        push(EV_DONE, 0, cyc + 5);
        pulse_coin(COIN_10);
        checks++;
        if (credit !== 6'd15) begin
            failures++;
            $display("FAIL overpay_credit got=%0d required=15", credit);
        end
        drain();
        stock_m[3]--;
    endtask

    task automatic test_cancel();
        pulse_start();
        pulse_sel(2'd3);
        pulse_coin(COIN_2);
        pulse_coin(COIN_2);
        checks++;
        if (credit !== 6'd4) begin
            failures++;
            $display("FAIL cancel_credit got=%0d required=4", credit);
        end
        push(EV_CHANGE, int'(COIN_2), cyc + 1);
        push(EV_CHANGE, int'(COIN_2), cyc + 2);
        push(EV_DONE, 0, cyc + 3);
        pulse_cancel();
        drain();
        checks++;
        if (sold_out !== sold_model() || busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_end sold_out=%b busy=%0b required sold_out=%b busy=0",
                     sold_out, busy, sold_model());
        end
    endtask

    task automatic test_sold_out();
        for (int n = 0; n < 3; n++) begin
            pulse_start();
            pulse_sel(2'd0);
            push(EV_PROD, 0, cyc + 1);
            push(EV_DONE, 0, cyc + 2);
            pulse_coin(COIN_2);
            drain();
            stock_m[0]--;
        end
        checks++;
        if (sold_out !== sold_model()) begin
            failures++;
            $display("FAIL sold_out_after_buys got=%b required=%b", sold_out, sold_model());
        end
        pulse_start();
        push(EV_ERR, 0, cyc + 1);
        pulse_sel(2'd0);
        tick();
        checks++;
        if (busy !== 1'b1 || credit !== '0) begin
            failures++;
            $display("FAIL sold_out_stay_select busy=%0b credit=%0d required busy=1 credit=0", busy, credit);
        end
        push(EV_DONE, 0, cyc + 1);
        pulse_cancel();
        drain();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL sold_out_cancel_idle busy=%0b required=0", busy);
        end
        pulse_restock();
        for (int i = 0; i < NP; i++) stock_m[i] = 3;
        checks++;
        if (sold_out !== sold_model()) begin
            failures++;
            $display("FAIL restock got=%b required=%b", sold_out, sold_model());
        end
    endtask

    task automatic test_coin_ignored_in_select();
        pulse_start();
        pulse_coin(COIN_10);
        checks++;
        if (credit !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL select_coin credit=%0d busy=%0b required credit=0 busy=1", credit, busy);
        end
        pulse_sel(2'd0);
        push(EV_PROD, 0, cyc + 1);
        push(EV_CHANGE, int'(COIN_5), cyc + 2);
        push(EV_CHANGE, int'(COIN_2), cyc + 3);
        push(EV_CHANGE, int'(COIN_1), cyc + 4);
        push(EV_DONE, 0, cyc + 5);
        pulse_coin(COIN_10);
        checks++;
        if (credit !== 6'd10) begin
            failures++;
            $display("FAIL select_then_pay_credit got=%0d required=10", credit);
        end
        drain();
        stock_m[0]--;
    endtask

    task automatic test_reset_mid_collect();
        pulse_start();
        pulse_sel(2'd3);
        pulse_coin(COIN_5);
        checks++;
        if (credit !== 6'd5) begin
            failures++;
            $display("FAIL mid_collect_credit got=%0d required=5", credit);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) stock_m[i] = 3;
        checks++;
        if (busy !== 1'b0 || credit !== '0 || sold_out !== sold_model()) begin
            failures++;
            $display("FAIL mid_reset_state busy=%0b credit=%0d sold_out=%b required busy=0 credit=0 sold_out=%b",
                     busy, credit, sold_out, sold_model());
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (change_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_no_refund change_valid=%0b done=%0b required 0 0", change_valid, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay();
        test_cancel();
        test_sold_out();
        test_coin_ignored_in_select();
        test_reset_mid_collect();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached required finish");
        $fatal(1, "timeout");
    end

endmodule
